// File: rtl/cdb_arbiter_pkg.sv
// Shared FU/CDB definitions: sizes, index types, the broadcast entry and helpers
// used by the completion arbiter.
package cdb_arbiter_pkg;

    localparam int NUM_FU   = 5;
    localparam int NUM_CDB  = 2;
    localparam int NUM_ROB  = 8;
    localparam int NUM_PR   = 64;
    localparam int VAL_W    = 64;
    localparam int FU_IDX_W = $clog2(NUM_FU);
    localparam int ROB_W    = $clog2(NUM_ROB);
    localparam int PR_W     = $clog2(NUM_PR);

    typedef logic [FU_IDX_W-1:0] fu_idx_t;
    typedef logic [ROB_W-1:0]    rob_idx_t;
    typedef logic [PR_W-1:0]     pr_idx_t;

    typedef struct packed {
        logic             valid;
        pr_idx_t          T_idx;
        rob_idx_t         ROB_idx;
        logic [VAL_W-1:0] value;
    } cdb_entry_t;

    // FU index `off` positions after `base`, wrapping at NUM_FU.
    function automatic fu_idx_t fu_wrap(input fu_idx_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return fu_idx_t'(sum % NUM_FU);
    endfunction

    // Distances are taken from the rollback entry; NUM_ROB is a power of two,
    // so ROB_W-bit subtraction is the modulo. The rollback entry itself survives.
    function automatic logic rob_squashed(input logic en, input rob_idx_t idx,
                                          input rob_idx_t rb, input rob_idx_t tail);
        rob_idx_t d_idx;
        rob_idx_t d_tail;
        d_idx  = idx - rb;
        d_tail = tail - rb;
        return en && (d_idx != '0) && (d_idx <= d_tail);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU completion / CDB broadcast bundle between the functional units, the ROB
// and the completion arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    // Handshake: fu_done[i] is valid and CDB_valid[i] is accept; a transfer
    // happens on an edge where both are 1. The FU holds data while not accepted.
    logic [NUM_FU-1:0]         fu_done;
    logic [NUM_FU*PR_W-1:0]    fu_T_idx;
    logic [NUM_FU*ROB_W-1:0]   fu_ROB_idx;
    logic [NUM_FU*VAL_W-1:0]   fu_result;
    logic                      ROB_rollback_en;
    logic [ROB_W-1:0]          ROB_rollback_idx;
    logic [ROB_W-1:0]          ROB_tail_idx;
    logic [NUM_FU-1:0]         CDB_valid;
    logic [NUM_CDB-1:0]        CDB_broadcast_valid;
    logic [NUM_CDB*PR_W-1:0]   CDB_T_idx;
    logic [NUM_CDB*ROB_W-1:0]  CDB_ROB_idx;
    logic [NUM_CDB*VAL_W-1:0]  CDB_value;
    logic [FU_IDX_W-1:0]       dbg_rr_ptr;

    modport master (
        output fu_done, fu_T_idx, fu_ROB_idx, fu_result,
               ROB_rollback_en, ROB_rollback_idx, ROB_tail_idx,
        input  CDB_valid, CDB_broadcast_valid, CDB_T_idx, CDB_ROB_idx, CDB_value,
               dbg_rr_ptr
    );

    modport slave (
        input  fu_done, fu_T_idx, fu_ROB_idx, fu_result,
               ROB_rollback_en, ROB_rollback_idx, ROB_tail_idx,
        output CDB_valid, CDB_broadcast_valid, CDB_T_idx, CDB_ROB_idx, CDB_value,
               dbg_rr_ptr
    );

endinterface

// File: rtl/cdb_arbiter_rr_multi_select.sv
// Rotating-priority pick of up to NUM_CDB requesters, scanning from `start`.
// Slot s receives the s-th requester found in scan order.
module cdb_arbiter_rr_multi_select
    import cdb_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0]  req,
    input  fu_idx_t            start,
    output logic [NUM_FU-1:0]  grant,
    output logic [NUM_CDB-1:0] slot_valid,
    output fu_idx_t            slot_idx [NUM_CDB],
    output logic               any_grant,
    output fu_idx_t            last_idx
);

    always_comb begin
        grant      = '0;
        slot_valid = '0;
        last_idx   = start;
        for (int s = 0; s < NUM_CDB; s++) begin
            slot_idx[s] = '0;
        end
        // Each slot takes the first requester in scan order not already granted.
        for (int s = 0; s < NUM_CDB; s++) begin
            for (int k = 0; k < NUM_FU; k++) begin
                fu_idx_t idx;
                idx = fu_wrap(start, k);
                if (!slot_valid[s] && req[idx] && !grant[idx]) begin
                    slot_valid[s] = 1'b1;
                    slot_idx[s]   = idx;
                    grant[idx]    = 1'b1;
                    last_idx      = idx;
                end
            end
        end
    end

    assign any_grant = |slot_valid;

endmodule

// File: rtl/cdb_arbiter.sv
// Completion arbiter: filters rollback-stale results, grants up to NUM_CDB live
// FUs round-robin and broadcasts them on registered CDB slots one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);

    logic [NUM_FU-1:0]  squash;
    logic [NUM_FU-1:0]  live_req;
    logic [NUM_FU-1:0]  drain;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_CDB-1:0] slot_valid;
    fu_idx_t            slot_idx [NUM_CDB];
    fu_idx_t            last_idx;
    fu_idx_t            rr_ptr;
    logic               any_grant;
    cdb_entry_t         slot_d [NUM_CDB];
    cdb_entry_t         slot_q [NUM_CDB];

    always_comb begin
        squash = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            squash[i] = rob_squashed(bus.ROB_rollback_en,
                                     bus.fu_ROB_idx[i*ROB_W +: ROB_W],
                                     bus.ROB_rollback_idx, bus.ROB_tail_idx);
        end
    end

    // Stale results are accepted so the FU drains, but never compete for a slot.
    assign live_req = reset ? '0 : (bus.fu_done & ~squash);
    assign drain    = reset ? '0 : (bus.fu_done & squash);

    cdb_arbiter_rr_multi_select u_select (
        .req        (live_req),
        .start      (rr_ptr),
        .grant      (grant),
        .slot_valid (slot_valid),
        .slot_idx   (slot_idx),
        .any_grant  (any_grant),
        .last_idx   (last_idx)
    );

    assign bus.CDB_valid = grant | drain;

    always_comb begin
        for (int s = 0; s < NUM_CDB; s++) begin
            slot_d[s]       = '0;
            slot_d[s].valid = slot_valid[s];
            for (int k = 0; k < NUM_FU; k++) begin
                if (slot_idx[s] == fu_idx_t'(k)) begin
                    slot_d[s].T_idx   = bus.fu_T_idx[k*PR_W +: PR_W];
                    slot_d[s].ROB_idx = bus.fu_ROB_idx[k*ROB_W +: ROB_W];
                    slot_d[s].value   = bus.fu_result[k*VAL_W +: VAL_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int s = 0; s < NUM_CDB; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_CDB; s++) begin
                slot_q[s] <= slot_d[s];
            end
            if (any_grant) begin
                rr_ptr <= fu_wrap(last_idx, 1);
            end
        end
    end

    always_comb begin
        bus.CDB_broadcast_valid = '0;
        bus.CDB_T_idx           = '0;
        bus.CDB_ROB_idx         = '0;
        bus.CDB_value           = '0;
        for (int s = 0; s < NUM_CDB; s++) begin
            bus.CDB_broadcast_valid[s]          = slot_q[s].valid;
            bus.CDB_T_idx[s*PR_W +: PR_W]       = slot_q[s].T_idx;
            bus.CDB_ROB_idx[s*ROB_W +: ROB_W]   = slot_q[s].ROB_idx;
            bus.CDB_value[s*VAL_W +: VAL_W]     = slot_q[s].value;
        end
    end

    assign bus.dbg_rr_ptr = rr_ptr;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Consumer end of the functional-unit completion interface. Each cycle it collects finished results from all FUs (ALU, mult pipelines, branch), picks up to NUM_CDB of them with round-robin priority, and returns the per-FU CDB_valid grant that lets an FU retire its output stage. It then broadcasts the granted results on registered CDB slots to the ROB, RS and physical register file. It also discards results that a ROB rollback makes stale.

Parameters:
NUM_FU, 5, number of FU result ports
NUM_CDB, 2, broadcast slots per cycle
NUM_ROB, 8, ROB entries (index width $clog2(NUM_ROB))
NUM_PR, 64, physical registers (tag width $clog2(NUM_PR))

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
fu_done  in  NUM_FU  FU i holds a finished result
fu_T_idx  in  NUM_FU*$clog2(NUM_PR)  dest physical tag per FU
fu_ROB_idx  in  NUM_FU*$clog2(NUM_ROB)  ROB index per FU
fu_result  in  NUM_FU*64  result value per FU
ROB_rollback_en  in  1  rollback this cycle
ROB_rollback_idx  in  $clog2(NUM_ROB)  mispredicted (surviving) entry
ROB_tail_idx  in  $clog2(NUM_ROB)  youngest allocated entry
CDB_valid  out  NUM_FU  combinational grant/accept per FU
CDB_broadcast_valid  out  NUM_CDB  registered slot valid
CDB_T_idx  out  NUM_CDB*$clog2(NUM_PR)  registered slot tag
CDB_ROB_idx  out  NUM_CDB*$clog2(NUM_ROB)  registered slot ROB index
CDB_value  out  NUM_CDB*64  registered slot value

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset values: all registered outputs are 0. rr_ptr is 0. CDB_valid is 0 while reset is high, regardless of fu_done.
- Handshake: an FU holds fu_done and its data stable until it sees CDB_valid[i]=1 in the same cycle. The FU releases or advances on the following edge. The arbiter never grants an FU whose fu_done is 0.
- Squash test, combinational:
  - d(x) = (x - ROB_rollback_idx) mod NUM_ROB.
  - An entry is squashed iff ROB_rollback_en=1 and 1 <= d(fu_ROB_idx) <= d(ROB_tail_idx).
  - The rollback entry itself (d=0) survives.
- Squashed done FUs: CDB_valid[i]=1 so the FU drains, but nothing is broadcast and no slot is consumed.
- Selection:
  - Scan FUs starting at rr_ptr and wrapping modulo NUM_FU.
  - The first NUM_CDB FUs that are done and not squashed are granted, in scan order, to slot 0, slot 1, and so on.
  - Unselected live FUs get CDB_valid=0 and retry next cycle.
- Broadcast: 1-cycle latency. Granted entries are registered at the edge and appear on the CDB_* outputs the next cycle. Unused slots have valid 0; their data fields hold don't-care values and the bench must not check them.
- Pointer update: if any live grant occurred, rr_ptr = (index of last live-granted FU + 1) mod NUM_FU. Otherwise rr_ptr is unchanged. Squash-only drains do not move rr_ptr.
- Rollback timing: only candidates in the rollback cycle are filtered. Slots already registered (visible that cycle) are not retracted.
- ZERO_PR tags: broadcast normally so the ROB still marks completion.
- Reset mid-operation: takes effect at the next edge. Pending registered slots are cleared and no grant is issued in the reset cycle.

Decomposition:
- Shared FU package (FU.vh): typedef CDB_ENTRY_t {valid, T_idx, ROB_idx, value}; constants NUM_CDB and NUM_FU; the existing NUM_ROB, NUM_PR and ZERO_PR.
- One combinational sub-module, rr_multi_select: a rotating-priority pick of up to NUM_CDB requesters from a request vector and start pointer. It returns the grant vector, per-slot FU index and last-granted index.
- The squash filter and pipeline register stay in cdb_arbiter.

Test Plan:
1. Reset: reset=1 for 2 cycles with fu_done=5'b11111 -> CDB_valid=0, CDB_broadcast_valid=0. After release, the first grant is 5'b00011.
2. Single result: fu_done=5'b00100, T=12, ROB=3, value=0x42 -> CDB_valid=5'b00100 that cycle. Next cycle broadcast_valid=2'b01 with slot0 {12,3,0x42}. The cycle after, broadcast_valid=0.
3. Contention: all 5 FUs done continuously. Grants over 4 cycles are 00011, 01100, 10001, 00110. The third-cycle broadcast has slot0=FU4 and slot1=FU0.
4. Rollback (rollback_idx=5, tail=2): FU0 ROB7, FU1 ROB3, FU2 ROB5 all done -> CDB_valid=5'b00111. Next cycle FU1 is broadcast in slot0 and FU2 in slot1; FU0 is dropped. rr_ptr becomes 3.
5. Wrap squash (rollback_idx=6, tail=1): ROB0 is squashed (d=2<=3). ROB6 (d=0) and ROB2 (d=4) are broadcast.
6. Mid-operation reset: assert reset while slot0 is valid -> next cycle all outputs are 0 and a held fu_done is not granted until reset drops.
